tile_walker: RTL and testbench

- Rasterizer stage directly upstream of plane_eq.
- Accepts one primitive command: a screen-space bounding box plus the depth plane coefficients dzdx, dzdy and c.
- Walks the box in SIZE x SIZE tiles aligned to SIZE and emits one tile origin (x, y) per valid/ready handshake.
- Holds the latched coefficients stable on its outputs so plane_eq can evaluate each tile.

---
 rtl/rast_pkg.sv | 29 ++
 rtl/tile_walker.sv | 146 ++++++++++++++
 tb/tb_tile_walker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rast_pkg.sv
// ============================================================================
// Module : rast_pkg
// Brief  : Shared rasterizer types, defaults, tile alignment helper and walker states
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

package rast_pkg;

  localparam int RAST_CW   = 16;
  localparam int RAST_ZW   = 18;
  localparam int TILE_SIZE = 2;

  typedef logic [RAST_CW-1:0] coord_t;
  typedef logic [RAST_ZW-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } walk_state_t;

  function automatic coord_t align_down(input coord_t coord, input int unsigned size);
    return coord & ~coord_t'(size - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_walker.sv
// ============================================================================
// Module : tile_walker
// Brief  : Walks a bounding box in SIZE x SIZE aligned tiles, one origin per handshake.
//          Optional macro TILE_WALKER_SERPENTINE_EN: odd rows run right to left.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module tile_walker
  import rast_pkg::*;
#(
  parameter int SIZE = TILE_SIZE,
  parameter int CW   = RAST_CW,
  parameter int ZW   = RAST_ZW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_xmin,
  input  logic [CW-1:0] cmd_ymin,
  input  logic [CW-1:0] cmd_xmax,
  input  logic [CW-1:0] cmd_ymax,
  input  logic [ZW-1:0] cmd_dzdx,
  input  logic [ZW-1:0] cmd_dzdy,
  input  logic [ZW-1:0] cmd_c,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [CW-1:0] tile_x,
  output logic [CW-1:0] tile_y,
  output logic          tile_last,
  output logic [ZW-1:0] dzdx,
  output logic [ZW-1:0] dzdy,
  output logic [ZW-1:0] c,
  output logic          done
);

  localparam logic [CW-1:0] c_STEP = CW'(SIZE);

  walk_state_t r_state;
  walk_state_t w_state_nxt;

  logic [CW-1:0] r_xs, r_xe, r_ys, r_ye;
  logic [CW-1:0] r_x, r_y;
  logic [ZW-1:0] r_dzdx, r_dzdy, r_c;

  logic          w_empty;
  logic          w_hs;
  logic          w_at_row_end;
  logic          w_at_last;
  logic [CW-1:0] w_row_end;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_row_start;

  assign w_empty = (cmd_xmin > cmd_xmax) || (cmd_ymin > cmd_ymax);
  assign w_hs    = (r_state == WALK) && tile_ready;

`ifdef TILE_WALKER_SERPENTINE_EN
  logic r_odd;

  assign w_row_end   = r_odd ? r_xs : r_xe;
  assign w_x_next    = r_odd ? (r_x - c_STEP) : (r_x + c_STEP);
  // The row after an even row is odd and therefore starts from the right end.
  assign w_row_start = r_odd ? r_xs : r_xe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_odd <= 1'b0;
    end else if ((r_state == IDLE) && cmd_valid) begin
      r_odd <= 1'b0;
    end else if (w_hs && w_at_row_end && (r_y != r_ye)) begin
      r_odd <= ~r_odd;
    end
  end
`else
  assign w_row_end   = r_xe;
  assign w_x_next    = r_x + c_STEP;
  assign w_row_start = r_xs;
`endif

  // End detection compares against aligned ends only, so the top of the range never wraps.
  assign w_at_row_end = (r_x == w_row_end);
  assign w_at_last    = w_at_row_end && (r_y == r_ye);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (cmd_valid) w_state_nxt = w_empty ? DONE : WALK;
      WALK: if (w_hs && w_at_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xs   <= '0;
      r_xe   <= '0;
      r_ys   <= '0;
      r_ye   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_dzdx <= '0;
      r_dzdy <= '0;
      r_c    <= '0;
    end else if ((r_state == IDLE) && cmd_valid) begin
      r_xs   <= align_down(cmd_xmin, SIZE);
      r_xe   <= align_down(cmd_xmax, SIZE);
      r_ys   <= align_down(cmd_ymin, SIZE);
      r_ye   <= align_down(cmd_ymax, SIZE);
      r_x    <= align_down(cmd_xmin, SIZE);
      r_y    <= align_down(cmd_ymin, SIZE);
      r_dzdx <= cmd_dzdx;
      r_dzdy <= cmd_dzdy;
      r_c    <= cmd_c;
    end else if (w_hs) begin
      if (!w_at_row_end) begin
        r_x <= w_x_next;
      end else if (r_y != r_ye) begin
        r_x <= w_row_start;
        r_y <= r_y + c_STEP;
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign tile_valid = (r_state == WALK);
  assign tile_last  = tile_valid && w_at_last;
  assign done       = (r_state == DONE);
  assign tile_x     = r_x;
  assign tile_y     = r_y;
  assign dzdx       = r_dzdx;
  assign dzdy       = r_dzdy;
  assign c          = r_c;

endmodule

`default_nettype wire

// File: tb/tb_tile_walker.sv
// ============================================================================
// Module : tb_tile_walker
// Brief  : Directed scoreboard bench for tile_walker (SIZE=2, CW=16, ZW=18)
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module tb_tile_walker;

  localparam int SIZE = 2;
  localparam int CW   = 16;
  localparam int ZW   = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_xmin, cmd_ymin, cmd_xmax, cmd_ymax;
  logic [ZW-1:0] cmd_dzdx, cmd_dzdy, cmd_c;
  logic          tile_valid;
  logic          tile_ready;
  logic [CW-1:0] tile_x, tile_y;
  logic          tile_last;
  logic [ZW-1:0] dzdx, dzdy, c;
  logic          done;

  always #5 clk = ~clk;

  tile_walker #(.SIZE(SIZE), .CW(CW), .ZW(ZW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_xmin  (cmd_xmin),
    .cmd_ymin  (cmd_ymin),
    .cmd_xmax  (cmd_xmax),
    .cmd_ymax  (cmd_ymax),
    .cmd_dzdx  (cmd_dzdx),
    .cmd_dzdy  (cmd_dzdy),
    .cmd_c     (cmd_c),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .tile_last (tile_last),
    .dzdx      (dzdx),
    .dzdy      (dzdy),
    .c         (c),
    .done      (done)
  );

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
  } tile_t;

  tile_t         exp_q[$];
  logic [ZW-1:0] exp_dzdx, exp_dzdy, exp_c;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference tile order for one command, built from the box alone.
  task automatic build(input int xmin, input int ymin, input int xmax, input int ymax);
    int xs, xe, ys, ye, row, x, xa, xb, dir;
    tile_t t;
    exp_q.delete();
    if (xmin > xmax || ymin > ymax) return;
    xs = xmin & ~(SIZE - 1);
    xe = xmax & ~(SIZE - 1);
    ys = ymin & ~(SIZE - 1);
    ye = ymax & ~(SIZE - 1);
    row = 0;
    for (int y = ys; y <= ye; y += SIZE) begin
      xa = xs; xb = xe; dir = SIZE;
`ifdef TILE_WALKER_SERPENTINE_EN
      if (row % 2 == 1) begin xa = xe; xb = xs; dir = -SIZE; end
`endif
      x = xa;
      forever begin
        t.x    = CW'(x);
        t.y    = CW'(y);
        t.last = (y == ye) && (x == xb);
        exp_q.push_back(t);
        if (x == xb) break;
        x += dir;
      end
      row++;
    end
  endtask

  task automatic run_cmd(input int xmin, input int ymin, input int xmax, input int ymax,
                         input logic [ZW-1:0] dx, input logic [ZW-1:0] dy, input logic [ZW-1:0] cc,
                         input int stall_at, input int stall_len, input int abort_at);
    int  idx   = 0;
    int  stall = 0;
    bit  fin   = 0;
    build(xmin, ymin, xmax, ymax);
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_xmin   = CW'(xmin);
    cmd_ymin   = CW'(ymin);
    cmd_xmax   = CW'(xmax);
    cmd_ymax   = CW'(ymax);
    cmd_dzdx   = dx;
    cmd_dzdy   = dy;
    cmd_c      = cc;
    tile_ready = 1'b1;
    exp_dzdx = dx; exp_dzdy = dy; exp_c = cc;
    step();
    cmd_valid = 1'b0;
    cmd_dzdx  = ~dx;
    cmd_dzdy  = ~dy;
    cmd_c     = ~cc;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      check("dzdx", dzdx, exp_dzdx);
      check("dzdy_c", {dzdy, c}, {exp_dzdy, exp_c});
      if (exp_q.size() > 0) begin
        check("tile_valid", tile_valid, 1);
        check("tile", {tile_x, tile_y, tile_last}, exp_q[0]);
        check("busy_flags", {done, cmd_ready}, 2'b00);
        if (idx == abort_at) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          check("rst_tile_valid", tile_valid, 0);
          check("rst_cmd_ready", cmd_ready, 1);
          check("rst_outputs", {tile_x, tile_y, tile_last, dzdx, done}, 0);
          for (int k = 0; k < 3; k++) begin
            step();
            check("rst_no_done", {done, tile_valid}, 2'b00);
          end
          exp_q.delete();
          fin = 1;
        end else begin
          if (idx == stall_at && stall < stall_len) begin
            tile_ready = 1'b0;
            stall++;
          end else begin
            tile_ready = 1'b1;
          end
          if (tile_ready) begin
            void'(exp_q.pop_front());
            idx++;
          end
          step();
        end
      end else begin
        check("done_pulse", {done, tile_valid, cmd_ready}, 3'b100);
        step();
        check("done_end", {done, tile_valid, cmd_ready}, 3'b001);
        fin = 1;
      end
    end
    if (!fin) check("timeout", 0, 1);
    tile_ready = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_xmin   = '0; cmd_ymin = '0; cmd_xmax = '0; cmd_ymax = '0;
    cmd_dzdx   = '0; cmd_dzdy = '0; cmd_c    = '0;
    tile_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_state", {cmd_ready, tile_valid, tile_last, done}, 4'b1000);
    check("reset_coords", {tile_x, tile_y, dzdx, dzdy, c}, 0);

    // single row
    run_cmd(0, 0, 3, 1, 18'h00123, 18'h00456, 18'h3FFFF, -1, 0, -1);
    // multi-row, no gap between rows
    run_cmd(1, 1, 4, 2, 18'h0F800, 18'h00010, 18'h20000, -1, 0, -1);
    // backpressure on the second tile
    run_cmd(1, 1, 4, 2, 18'h0F800, 18'h00011, 18'h00001, 1, 3, -1);
    // degenerate box
    run_cmd(5, 0, 4, 3, 18'h00ABC, 18'h00DEF, 18'h01234, -1, 0, -1);
    // top of coordinate range
    run_cmd(16'hFFFC, 0, 16'hFFFF, 0, 18'h15555, 18'h0AAAA, 18'h00777, -1, 0, -1);
    // reset while the third tile is presented
    run_cmd(1, 1, 4, 2, 18'h0F800, 18'h00022, 18'h00033, -1, 0, 2);
    // walker still works after an aborted command
    run_cmd(2, 3, 5, 6, 18'h00042, 18'h00043, 18'h00044, 0, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
